mux_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1-multiplexed resource (e.g. a memory or ALU port) among four requesters.
- Drives the select of the resource's 4:1 data mux, and one-hot grants back to the requesters.
- Holds a grant until the resource signals completion, the owner withdraws, or a hold timeout expires while others are waiting.
- Sits between requesting pipeline units and the shared datapath mux in the processor.

---
 rtl/mux_share_arbiter_if.sv | 33 +++
 rtl/mux_share_arbiter.sv | 109 ++++++++++
 tb/tb_mux_share_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mux_share_arbiter_if.sv
// Handshake bundle between the requesting units, the shared resource and the
// round-robin arbiter that owns the resource's 4:1 data mux select.
interface mux_share_arbiter_if;
  logic [3:0] req_in;
  logic       done_in;
  logic [3:0] grant_out;
  logic [1:0] select_out;
  logic       valid_out;
  logic       busy_out;
  logic       timeout_out;

  // Arbiter side: consumes requests and completion, drives grants and mux select.
  modport slave (
    input  req_in,
    input  done_in,
    output grant_out,
    output select_out,
    output valid_out,
    output busy_out,
    output timeout_out
  );

  // Requester / resource side.
  modport master (
    output req_in,
    output done_in,
    input  grant_out,
    input  select_out,
    input  valid_out,
    input  busy_out,
    input  timeout_out
  );
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one 4:1-multiplexed resource among four
// requesters. A grant is held until the resource reports done, the owner
// withdraws, or a hold timeout expires while another requester is waiting.
// Every release is followed by exactly one idle cycle before re-arbitration.
module mux_share_arbiter #(
  parameter int HOLD_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  mux_share_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Counter value at which the hold limit is reached (only used when MAX_HOLD != 0).
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  logic [0:0]        state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q,   sel_d;
  logic [1:0]        ptr_q,   ptr_d;
  logic [HOLD_W-1:0] cnt_q,   cnt_d;
  logic              tmo_q,   tmo_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       rel_done, rel_wd, rel_tmo;

  // Round-robin search: first set request starting at ptr; scanning the
  // offsets from 3 down to 0 lets the nearest one overwrite the others.
  always_comb begin
    found  = |bus.req_in;
    winner = ptr_q;
    idx    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (bus.req_in[idx]) winner = idx;
    end
  end

  // Release causes while granted; the owner index is held in sel_q.
  always_comb begin
    rel_done = bus.done_in;
    rel_wd   = ~bus.req_in[sel_q];
    rel_tmo  = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM) &&
               ((bus.req_in & ~grant_q) != 4'b0000);
  end

  // Next-state logic for the IDLE/GRANT controller.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (rel_done || rel_wd || rel_tmo) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          // Flag a forced release only when nothing else would have released.
          tmo_d   = rel_tmo && !rel_done && !rel_wd;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything immediately, even mid-grant.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant_out   = grant_q;
  assign bus.select_out  = sel_q;
  assign bus.valid_out   = |grant_q;
  assign bus.busy_out    = (state_q == S_GRANT);
  assign bus.timeout_out = tmo_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for the round-robin shared-resource arbiter (MAX_HOLD = 4).
module tb_mux_share_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_drop;

  mux_share_arbiter_if bus ();

  mux_share_arbiter #(
    .HOLD_W  (8),
    .MAX_HOLD(4)
  ) dut (
    .clk_in    (clk),
    .reset_n_in(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic tmo);
    check_val({tag, ".grant"}, bus.grant_out, g);
    check_val({tag, ".sel"}, bus.select_out, s);
    check_val({tag, ".valid"}, bus.valid_out, |g);
    check_val({tag, ".busy"}, bus.busy_out, |g);
    check_val({tag, ".tmo"}, bus.timeout_out, tmo);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    n_drop      = 0;
    rst_n       = 1'b0;
    bus.req_in  = 4'b0000;
    bus.done_in = 1'b0;

    // Reset state
    tick();
    tick();
    check_out("rst_state", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Asynchronous reset mid-grant to requester 2
    bus.req_in = 4'b0100;
    tick();
    check_out("pre_rst_grant", 4'b0100, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 4'b0000, 2'd0, 1'b0);
    #1 rst_n = 1'b1;
    bus.req_in = 4'b1111;
    tick();
    check_out("post_rst_first", 4'b0001, 2'd0, 1'b0);
    bus.req_in = 4'b0000;
    tick();
    check_out("post_rst_rel", 4'b0000, 2'd0, 1'b0);

    // Single request, done pulse releases (ptr was 1 -> owner 2 then ptr 3)
    bus.req_in = 4'b0100;
    tick();
    check_out("single_grant", 4'b0100, 2'd2, 1'b0);
    tick();
    tick();
    check_out("single_hold", 4'b0100, 2'd2, 1'b0);
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    check_out("single_done", 4'b0000, 2'd2, 1'b0);
    bus.req_in = 4'b1111;
    tick();
    check_out("single_next3", 4'b1000, 2'd3, 1'b0);
    bus.req_in = 4'b0000;
    tick();
    check_out("single_wd", 4'b0000, 2'd3, 1'b0);

    // Round robin with done on every grant cycle: 0,1,2,3,0
    bus.req_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rr_grant%0d", i), 4'b0001 << (i % 4), 2'(i % 4), 1'b0);
      bus.done_in = 1'b1;
      tick();
      bus.done_in = 1'b0;
      check_out($sformatf("rr_dead%0d", i), 4'b0000, 2'(i % 4), 1'b0);
      if (i == 4) bus.req_in = 4'b0000;
    end
    tick();
    check_out("rr_idle", 4'b0000, 2'd0, 1'b0);

    // Timeout with competitor (ptr=1, only req 0 -> owner 0)
    bus.req_in = 4'b0001;
    tick();
    check_out("tmo_grant", 4'b0001, 2'd0, 1'b0);
    bus.req_in = 4'b0011;
    tick();
    tick();
    tick();
    check_out("tmo_hold3", 4'b0001, 2'd0, 1'b0);
    tick();
    check_out("tmo_release", 4'b0000, 2'd0, 1'b1);
    tick();
    check_out("tmo_next1", 4'b0010, 2'd1, 1'b0);
    bus.req_in = 4'b0000;
    tick();
    check_out("tmo_wd1", 4'b0000, 2'd1, 1'b0);

    // No competitor: owner 0 holds for 100 cycles (ptr=2)
    bus.req_in = 4'b0001;
    tick();
    check_out("hold_grant", 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.grant_out != 4'b0001 || bus.timeout_out) n_drop++;
    end
    check_val("hold_drops", n_drop, 0);
    check_out("hold_end", 4'b0001, 2'd0, 1'b0);

    // Withdrawal of owner 1 -> ptr becomes 2
    bus.req_in = 4'b0000;
    tick();
    bus.req_in = 4'b0010;
    tick();
    check_out("wd_grant1", 4'b0010, 2'd1, 1'b0);
    tick();
    bus.req_in = 4'b0000;
    tick();
    check_out("wd_release", 4'b0000, 2'd1, 1'b0);
    bus.req_in = 4'b1111;
    tick();
    check_out("wd_ptr2", 4'b0100, 2'd2, 1'b0);

    // done coincides with timeout condition -> plain release, one dead cycle
    tick();
    tick();
    tick();
    check_out("sim_hold", 4'b0100, 2'd2, 1'b0);
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    check_out("sim_release", 4'b0000, 2'd2, 1'b0);
    tick();
    check_out("sim_next3", 4'b1000, 2'd3, 1'b0);

    // done in IDLE is ignored
    bus.req_in = 4'b0000;
    tick();
    bus.done_in = 1'b1;
    tick();
    bus.done_in = 1'b0;
    check_out("idle_done", 4'b0000, 2'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
